// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that lets NUM_REQ byte producers share one UART transmitter.
// It issues one start pulse per frame, then applies a watchdog and an idle gap between frames.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 timeout_err
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACC  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
    localparam logic [2:0]  LAST_IDX = 3'(NUM_REQ - 1);

    logic [2:0]         state_q, state_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic               timeout_err_q, timeout_err_d;

    logic [7:0]         validPad;
    logic [3:0]         scanIdx;
    logic               pickFound;
    logic [2:0]         pickIdx;
    logic [7:0]         pickData;
    logic [NUM_REQ-1:0] pickAck;
    logic [15:0]        cntInc;

    assign validPad = 8'(req_valid);
    assign cntInc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // First valid requester found scanning upward from rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        scanIdx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = {1'b0, rr_ptr_q} + 4'(k);
            if (scanIdx >= 4'(NUM_REQ)) begin
                scanIdx = scanIdx - 4'(NUM_REQ);
            end
            if (!pickFound && validPad[scanIdx[2:0]]) begin
                pickFound = 1'b1;
                pickIdx   = scanIdx[2:0];
            end
        end
    end

    always_comb begin
        pickData = '0;
        pickAck  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickIdx == 3'(i)) begin
                pickData   = req_data[8*i +: 8];
                pickAck[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        req_ack_d     = '0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (pickFound) begin
                    tx_data_d  = pickData;
                    grant_id_d = pickIdx;
                    req_ack_d  = pickAck;
                    rr_ptr_d   = (pickIdx == LAST_IDX) ? 3'd0 : pickIdx + 3'd1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACC;
            end
            ST_WAIT_ACC: begin
                if (!tx_done) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_GAP;
                end else begin
                    cnt_d = cntInc;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_GAP;
                end else begin
                    cnt_d = cntInc;
                end
            end
            ST_GAP: begin
                // A zero-length gap still spends one cycle here before returning to IDLE.
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cntInc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            req_ack_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            req_ack_q     <= req_ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign tx_start    = (state_q == ST_START);
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a round-robin model predicts each grant,
// and a monitor compares each captured frame against the queue of predicted grants.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 16;
    localparam int TMO  = 100;

    typedef struct {
        int id;
        int data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [2:0]  grant_id;
    logic        timeout_err;

    logic        rst0_n;
    logic [3:0]  req_valid0;
    logic [31:0] req_data0;
    logic [3:0]  req_ack0;
    logic        tx_start0;
    logic [7:0]  tx_data0;
    logic        tx_done0;
    logic        busy0;
    logic [2:0]  grant_id0;
    logic        timeout_err0;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    int   modelPtr = 0;
    int   planCount[NREQ];
    int   planData[NREQ][4];
    int   pendBuf[NREQ][4];
    int   pendHead[NREQ];
    int   pendCount[NREQ];
    int   startCycles = 0;
    int   txLen = 0;
    int   txRemain = 0;
    bit   hangTx = 1'b0;
    bit   dut0Done = 1'b0;
    int   since0 = 0;
    int   remain0 = 0;
    int   measured0 = 0;
    int   guard0 = 0;
    int   expId0 = 0;
    bit   measuring0 = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NUM_REQ(NREQ), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst_n(rst0_n), .req_valid(req_valid0), .req_data(req_data0),
        .req_ack(req_ack0), .tx_start(tx_start0), .tx_data(tx_data0), .tx_done(tx_done0),
        .busy(busy0), .grant_id(grant_id0), .timeout_err(timeout_err0)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Predicts the grant order of a batch with plain round-robin over remaining byte counts.
    task automatic applyStimulus();
        int rem[NREQ];
        int idx[NREQ];
        int total;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i]       = planCount[i];
            idx[i]       = 0;
            total        += rem[i];
            pendHead[i]  = 0;
            pendCount[i] = planCount[i];
            for (int j = 0; j < 4; j++) pendBuf[i][j] = planData[i][j];
        end
        while (total > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (modelPtr + k) % NREQ;
                if (rem[c] > 0) begin
                    expQ.push_back('{c, planData[c][idx[c]]});
                    idx[c]++;
                    rem[c]--;
                    total--;
                    modelPtr = (c + 1) % NREQ;
                    break;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (pendCount[i] > 0);
            if (pendCount[i] > 0) req_data[8*i +: 8] = 8'(pendBuf[i][0]);
        end
    endtask

    task automatic clearPlan();
        for (int i = 0; i < NREQ; i++) begin
            planCount[i] = 0;
            for (int j = 0; j < 4; j++) planData[i][j] = 0;
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((expQ.size() != 0 || busy) && n < budget);
        checkOutput({name, "_idle_reached"}, int'(expQ.size() == 0 && !busy), 1);
    endtask

    // Requesters present their next byte after each ack, or drop valid when exhausted.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i]) begin
                    pendHead[i]++;
                    if (pendHead[i] < pendCount[i]) req_data[8*i +: 8] = 8'(pendBuf[i][pendHead[i]]);
                    else req_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (tx_start) startCycles++;
            if (rst_n && (req_ack != 4'd0 || tx_start)) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_grant", int'({tx_start, req_ack}), 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ack_onehot", int'(req_ack), 1 << e.id);
                    checkOutput("grant_id", int'(grant_id), e.id);
                    checkOutput("tx_data", int'(tx_data), e.data);
                    checkOutput("start_with_ack", int'(tx_start), 1);
                end
            end
        end
    end

    // Transmitter model: done drops on start and rises txRemain clocks later unless hung.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                tx_done  = 1'b0;
                txRemain = hangTx ? 0 : ((txLen > 0) ? txLen : int'($urandom_range(3, 30)));
            end else if (txRemain > 0) begin
                txRemain--;
                if (txRemain == 0) tx_done = 1'b1;
            end
        end
    end

    // Zero-gap instance: two requesters held valid, restart must follow done by 3 clocks.
    initial begin
        rst0_n     = 1'b0;
        tx_done0   = 1'b1;
        req_valid0 = 4'b0011;
        req_data0  = 32'h0000_2010;
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        while (measured0 < 4 && guard0 < 500) begin
            @(negedge clk);
            guard0++;
            if (measuring0) since0++;
            if (tx_start0) begin
                if (measuring0) begin
                    checkOutput("gap0_restart", since0, 3);
                    measured0++;
                end
                checkOutput("gap0_grant", int'(grant_id0), expId0);
                expId0     = expId0 ^ 1;
                tx_done0   = 1'b0;
                remain0    = 8;
                measuring0 = 1'b0;
            end else if (remain0 > 0) begin
                remain0--;
                if (remain0 == 0) begin
                    tx_done0   = 1'b1;
                    measuring0 = 1'b1;
                    since0     = 0;
                end
            end
        end
        checkOutput("gap0_measured", measured0, 4);
        dut0Done = 1'b1;
    end

    initial begin
        int n;
        int gapN;
        int pick;
        int startsBefore;

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = $urandom;
        tx_done   = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_ack", int'(req_ack), 0);
        checkOutput("reset_start", int'(tx_start), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_timeout", int'(timeout_err), 0);
        checkOutput("reset_grant_id", int'(grant_id), 0);
        checkOutput("reset_tx_data", int'(tx_data), 0);
        req_valid = 4'h0;
        rst_n     = 1'b1;
        modelPtr  = 0;
        @(negedge clk);

        $display("[TB] round robin with all requesters held");
        clearPlan();
        planCount = '{2, 1, 1, 1};
        planData[0][0] = 8'h11; planData[0][1] = 8'h55;
        planData[1][0] = 8'h22; planData[2][0] = 8'h33; planData[3][0] = 8'h44;
        startsBefore = startCycles;
        applyStimulus();
        waitIdle("rr", 1000);
        checkOutput("rr_start_count", startCycles - startsBefore, 5);

        $display("[TB] single request, latency and gap");
        clearPlan();
        planCount[2] = 1;
        planData[2][0] = 8'hA5;
        txLen = 50;
        applyStimulus();
        @(negedge clk);
        checkOutput("single_ack", int'(req_ack), 4'b0100);
        checkOutput("single_start", int'(tx_start), 1);
        checkOutput("single_grant", int'(grant_id), 2);
        checkOutput("single_data", int'(tx_data), 8'hA5);
        repeat (3) @(negedge clk);
        req_valid[0]    = 1'b1;
        req_data[7:0]   = 8'hEE;
        repeat (3) @(negedge clk);
        req_valid[0]    = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!tx_done && n < 200);
        checkOutput("single_done_seen", int'(tx_done), 1);
        gapN = 0;
        do begin
            @(negedge clk); #1;
            gapN++;
        end while (busy && gapN < 100);
        checkOutput("single_gap_len", gapN, GAP + 1);
        waitIdle("single", 200);
        txLen = 0;

        $display("[TB] randomized batches");
        repeat (12) begin
            clearPlan();
            for (int i = 0; i < NREQ; i++) begin
                planCount[i] = int'($urandom_range(0, 3));
                for (int j = 0; j < 4; j++) planData[i][j] = int'($urandom_range(0, 255));
            end
            if (planCount[0] + planCount[1] + planCount[2] + planCount[3] == 0) planCount[1] = 1;
            applyStimulus();
            waitIdle("random", 3000);
        end

        $display("[TB] watchdog abort");
        hangTx = 1'b1;
        clearPlan();
        pick = int'($urandom_range(0, NREQ - 1));
        planCount[pick] = 1;
        planData[pick][0] = int'($urandom_range(0, 255));
        applyStimulus();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 10);
        checkOutput("timeout_start_seen", int'(tx_start), 1);
        repeat (101) @(negedge clk);
        checkOutput("timeout_not_yet", int'(timeout_err), 0);
        checkOutput("timeout_still_busy", int'(busy), 1);
        @(negedge clk);
        checkOutput("timeout_raised", int'(timeout_err), 1);
        waitIdle("timeout", 200);
        hangTx = 1'b0;
        clearPlan();
        planCount[(pick + 1) % NREQ] = 1;
        planData[(pick + 1) % NREQ][0] = 8'h3C;
        applyStimulus();
        waitIdle("after_timeout", 200);
        checkOutput("timeout_sticky", int'(timeout_err), 1);

        $display("[TB] reset in the middle of a frame");
        clearPlan();
        planCount[2] = 1;
        planData[2][0] = 8'h5A;
        txLen = 60;
        applyStimulus();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 10);
        repeat (10) @(negedge clk);
        checkOutput("midframe_busy", int'(busy), 1);
        rst_n    = 1'b0;
        modelPtr = 0;
        clearPlan();
        planCount[1] = 1; planData[1][0] = 8'h71;
        planCount[3] = 1; planData[3][0] = 8'h73;
        applyStimulus();
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_start", int'(tx_start), 0);
        checkOutput("midreset_ack", int'(req_ack), 0);
        checkOutput("midreset_timeout", int'(timeout_err), 0);
        @(negedge clk);
        checkOutput("midreset_first_grant", int'(grant_id), 1);
        waitIdle("midreset", 400);
        txLen = 0;

        n = 0;
        while (!dut0Done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("gap0_finished", int'(dut0Done), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
